// File: rtl/fifo.sv
// Synchronous circular-buffer FIFO with registered read data and overflow/underflow flags.
// Define FIFO_ERR_STICKY_EN to make the error flags hold until reset instead of pulsing.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Storage is deliberately left out of reset; stale words are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[tail] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok) begin
                tail <= tail + 1'b1;
            end
            if (rd_ok) begin
                data_out <= mem[head];
                head     <= head + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
`ifdef FIFO_ERR_STICKY_EN
            overflow  <= overflow  | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
`else
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
`endif
        end
    end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 16, number of storage entries; a power of two, at least 2.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port data_in  input  WIDTH  word to enqueue.
REQ-006 SHALL provide port wr_en  input  1  write request, sampled at rising clk.
REQ-007 SHALL provide port rd_en  input  1  read request, sampled at rising clk.
REQ-008 SHALL provide port data_out  output  WIDTH  registered dequeued word.
REQ-009 SHALL provide port empty  output  1  high when count == 0.
REQ-010 SHALL provide port full  output  1  high when count == DEPTH.
REQ-011 SHALL provide port count  output  $clog2(DEPTH)+1  number of stored words.
REQ-012 SHALL provide port overflow  output  1  write rejected because the FIFO was full.
REQ-013 SHALL provide port underflow  output  1  read rejected because the FIFO was empty.

Function
REQ-014 SHALL order data first-in-first-out: push at the tail, pop from the head, in a circular buffer with head and tail pointers of $clog2(DEPTH) bits.
REQ-015 SHALL accept a write when wr_en=1 and full=0: store data_in at tail, tail+1 modulo DEPTH.
REQ-016 SHALL accept a read when rd_en=1 and empty=0: data_out <= mem[head] at that edge (1-cycle latency), head+1 modulo DEPTH.
REQ-017 SHALL hold data_out unchanged on any cycle with no accepted read.
REQ-018 SHALL wrap both pointers from DEPTH-1 to 0 with no loss of data or ordering.
REQ-019 SHALL, on the same edge, accept both operations and leave count unchanged when wr_en=1, rd_en=1, 0<count<DEPTH.
REQ-020 SHALL, when wr_en=1 and rd_en=1 while full: accept the read, reject the write, assert overflow, and end with count=DEPTH-1.
REQ-021 SHALL, when wr_en=1 and rd_en=1 while empty: accept the write, reject the read, assert underflow, leave data_out unchanged (no bypass), and end with count=1.
REQ-022 SHALL, on a rejected write, leave memory, pointers and count unchanged.
REQ-023 SHALL, on a rejected read, leave data_out, pointers and count unchanged.
REQ-024 SHALL update count as +1 for a write only, -1 for a read only, 0 for both or neither, counting accepted operations only.
REQ-025 SHALL drive empty, full and count as registered or combinational from registered state, consistent with count in the same cycle.

Reset
REQ-026 SHALL, on rst=1 at a rising clk, set head=0, tail=0, count=0, data_out=0, overflow=0, underflow=0, giving empty=1 and full=0.
REQ-027 SHALL give rst priority over wr_en and rd_en; a mid-operation reset discards all stored words.
REQ-028 SHALL NOT clear memory contents on reset; those contents SHALL be unobservable after reset.

Configuration
REQ-029 SHALL use macro FIFO_ERR_STICKY_EN to select error-flag behaviour.
REQ-030 SHALL, without FIFO_ERR_STICKY_EN, pulse overflow and underflow for exactly one cycle after each rejected operation.
REQ-031 SHALL, with FIFO_ERR_STICKY_EN, hold overflow and underflow high once set until rst; ports are identical in both builds.

Verification
REQ-032 SHALL cover fill and drain: reset, write 0x00..0x0F (16 writes) -> full=1, count=16; 16 reads -> data_out 0x00..0x0F in order, then empty=1.
REQ-033 SHALL cover overflow: when full, write 0xAA -> overflow=1 (1-cycle pulse, or sticky with the macro); count stays 16; 0xAA is never read.
REQ-034 SHALL cover underflow: when empty, 4 reads -> underflow=1, data_out holds its last value, count=0.
REQ-035 SHALL cover wrap-around: write 8, read 5, then write 13 -> full=1; 16 reads return the remaining 3 words of the first batch, then the 13 new words, in order.
REQ-036 SHALL cover simultaneous operations at the boundaries: wr+rd at count=5 -> count=5; at full -> count=15, overflow=1; at empty -> count=1, underflow=1.
REQ-037 SHALL cover reset mid-operation: write 6 words, assert rst for 1 cycle -> count=0, empty=1, data_out=0; the next read gives underflow=1.
